// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for instruction memory
// Assembles little-endian words from a length-prefixed stream and holds the core in reset until done.
module imem_loader #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32,
   parameter int IMEM_DEPTH = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [INST_WIDTH-1:0] imem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  cpu_rst_n
);

   typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERR} state_t;

   localparam logic [16:0] DEPTH_LIM = 17'(IMEM_DEPTH);

   state_t                state;
   state_t                state_nxt;
   logic [1:0]            byte_cnt;
   logic [ADDR_WIDTH-1:0] word_cnt;
   logic [ADDR_WIDTH-1:0] word_inc;
   logic [15:0]           len;
   logic [15:0]           len_full;
   logic [23:0]           shift_reg;
   logic                  accept;
   logic                  last_word;
   logic                  rearm;

   assign in_ready  = (state == LEN) || (state == DATA);
   assign busy      = in_ready;
   assign done      = (state == DONE);
   assign error     = (state == ERR);
   assign cpu_rst_n = done;

   assign accept    = in_valid && in_ready;
   assign rearm     = start && ((state == IDLE) || (state == DONE) || (state == ERR));
   assign len_full  = {in_data, len[7:0]};
   assign word_inc  = word_cnt + ADDR_WIDTH'(1);
   assign last_word = (word_inc == ADDR_WIDTH'(len));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = LEN;
         LEN: begin
            if (accept && byte_cnt == 2'd1) begin
               if (len_full == 16'd0)                   state_nxt = DONE;
               else if ({1'b0, len_full} > DEPTH_LIM)   state_nxt = ERR;
               else                                     state_nxt = DATA;
            end
         end
         DATA: if (accept && byte_cnt == 2'd3 && last_word) state_nxt = DONE;
         DONE: if (start) state_nxt = LEN;
         ERR:  if (start) state_nxt = LEN;
         default: state_nxt = IDLE;
      endcase
   end

   // byte_cnt doubles as the length-byte index in LEN and the byte lane in DATA
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt   <= 2'd0;
         word_cnt   <= '0;
         len        <= 16'd0;
         shift_reg  <= 24'd0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= 1'b0;
         if (rearm) begin
            byte_cnt <= 2'd0;
            word_cnt <= '0;
         end else if (accept) begin
            if (state == LEN) begin
               if (byte_cnt == 2'd0) begin
                  len[7:0] <= in_data;
                  byte_cnt <= 2'd1;
               end else begin
                  len[15:8] <= in_data;
                  byte_cnt  <= 2'd0;
               end
            end else begin
               byte_cnt <= byte_cnt + 2'd1;
               case (byte_cnt)
                  2'd0:    shift_reg[7:0]   <= in_data;
                  2'd1:    shift_reg[15:8]  <= in_data;
                  2'd2:    shift_reg[23:16] <= in_data;
                  default: begin
                     imem_we    <= 1'b1;
                     imem_addr  <= word_cnt;
                     imem_wdata <= INST_WIDTH'({in_data, shift_reg});
                     word_cnt   <= word_inc;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        busy;
   logic        done;
   logic        error;
   logic        cpu_rst_n;

   imem_loader #(.ADDR_WIDTH(32), .INST_WIDTH(32), .IMEM_DEPTH(1024)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .error(error), .cpu_rst_n(cpu_rst_n)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          we_cycles[$];
   logic [31:0] img[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (rst_n && imem_we) begin
         we_cycles.push_back(cyc);
         if (exp_q.size() == 0) begin
            check_eq("unexpected_we", 64'(imem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check_eq("we_addr", 64'(imem_addr), 64'(e.addr));
            check_eq("we_data", 64'(imem_wdata), 64'(e.data));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 50) begin
            check_eq("ready_timeout", 64'(in_ready), 64'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic gap_wait(input int g);
      repeat (g) begin
         check_eq("ready_in_gap", 64'(in_ready), 64'd1);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic load_image(input int gap, input bit poke);
      logic [15:0] nlen;
      nlen = 16'(img.size());
      pulse_start();
      check_eq("ready_after_start", 64'(in_ready), 64'd1);
      check_eq("cpu_rst_held", 64'(cpu_rst_n), 64'd0);
      check_eq("busy_loading", 64'(busy), 64'd1);
      send_byte(nlen[7:0]);
      gap_wait(gap);
      send_byte(nlen[15:8]);
      for (int w = 0; w < img.size(); w++) begin
         for (int b = 0; b < 4; b++) begin
            gap_wait(gap);
            if (b == 3) exp_q.push_back('{32'(w), img[w]});
            if (poke && w == 1 && b == 0) start = 1'b1;
            send_byte(img[w][8*b +: 8]);
            start = 1'b0;
         end
      end
      check_eq("final_we", 64'(imem_we), 64'd1);
      check_eq("done_with_last", 64'(done), 64'd1);
      check_eq("cpu_rst_rel", 64'(cpu_rst_n), 64'd1);
      check_eq("busy_end", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_outs"}, 64'({in_ready, imem_we, busy, done, error, cpu_rst_n}), 64'd0);
      check_eq({tag, "_addr"}, 64'(imem_addr), 64'd0);
      check_eq({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("idle_ready", 64'(in_ready), 64'd0);

      // back-to-back load, writes 4 cycles apart
      img = '{32'h002081B3, 32'h00200113, 32'h00C00193};
      we_cycles.delete();
      load_image(0, 1'b0);
      check_eq("n_writes", 64'(we_cycles.size()), 64'd3);
      if (we_cycles.size() == 3) begin
         check_eq("spacing01", 64'(we_cycles[1] - we_cycles[0]), 64'd4);
         check_eq("spacing12", 64'(we_cycles[2] - we_cycles[1]), 64'd4);
      end

      // in_valid toggling every other cycle
      load_image(1, 1'b0);

      // zero-length image
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h00);
      check_eq("zero_len_done", 64'(done), 64'd1);
      check_eq("zero_len_we", 64'(imem_we), 64'd0);

      // oversize length 1025
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h04);
      check_eq("oversize_err", 64'(error), 64'd1);
      check_eq("oversize_cpu_rst", 64'(cpu_rst_n), 64'd0);
      check_eq("oversize_ready", 64'(in_ready), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      img = '{32'hDEADBEEF};
      load_image(0, 1'b0);
      check_eq("err_cleared", 64'(error), 64'd0);

      // bytes offered in DONE are not consumed
      in_data = 8'h5A;
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_eq("done_hold", 64'(done), 64'd1);

      // reset mid-load after 2 bytes of word 1
      pulse_start();
      send_byte(8'h02);
      send_byte(8'h00);
      exp_q.push_back('{32'd0, 32'h11223344});
      send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
      send_byte(8'hAA); send_byte(8'hBB);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midload_reset");
      @(posedge clk);
      #1;
      check_eq("reset_queue", 64'(exp_q.size()), 64'd0);
      rst_n = 1'b1;
      img = '{32'hCAFEF00D, 32'h01234567};
      load_image(0, 1'b0);

      // start during DATA ignored; start in DONE reloads
      img = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0F0F_0003};
      load_image(0, 1'b1);
      load_image(0, 1'b0);

      repeat (4) @(posedge clk);
      #1;
      check_eq("end_queue", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
